// File: rtl/inst_rom_arbiter.sv
// inst_rom_arbiter
// Shares the instruction ROM read port between the CPU fetch stage and a
// debug/loader port. CPU fetch normally wins; a starvation counter forces a
// debug slot after STARVE_MAX consecutive CPU wins against a waiting debug
// request. The ROM word is captured at the granting edge and returned to the
// winner one cycle later.
module inst_rom_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_flush,
   output logic              cpu_stall,
   output logic              cpu_valid,
   output logic [DATA_W-1:0] cpu_inst,
   input  logic              dbg_req,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic              dbg_gnt,
   output logic              dbg_valid,
   output logic [DATA_W-1:0] dbg_inst,
   output logic              dbg_err,
   output logic              rom_ce,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_inst
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DBG  = 2'd2
   } owner_t;

   logic [3:0] starve_cnt;
   logic [3:0] starve_cnt_nxt;
   logic       starved;
   logic       dbg_win;
   logic       cpu_win;
   owner_t     owner_p1;
   owner_t     owner_nxt;
   logic       dbg_err_p1;

   // ---- stage p0: arbitration and ROM drive ----

   // Priority arbitration: debug wins when the CPU is idle or has starved it.
   always_comb begin
      starved = (starve_cnt == 4'(STARVE_MAX));
      dbg_win = dbg_req & (~cpu_req | starved);
      cpu_win = cpu_req & ~dbg_win;
   end

   // Grant and ROM outputs; forced quiet while reset is held.
   always_comb begin
      dbg_gnt   = 1'b0;
      cpu_stall = 1'b0;
      rom_ce    = 1'b0;
      rom_addr  = '0;
      if (!rst) begin
         dbg_gnt   = dbg_win;
         cpu_stall = cpu_req & ~cpu_win;
         rom_ce    = cpu_win | dbg_win;
         if (dbg_win)
            rom_addr = dbg_addr;
         else if (cpu_win)
            rom_addr = cpu_addr;
      end
   end

   // Starvation counter next value: counts CPU wins over a waiting debug request, saturating.
   always_comb begin
      starve_cnt_nxt = starve_cnt;
      if (dbg_win || !dbg_req)
         starve_cnt_nxt = 4'd0;
      else if (cpu_win && starve_cnt < 4'(STARVE_MAX))
         starve_cnt_nxt = starve_cnt + 4'd1;
   end

   // Response owner for next cycle; a CPU grant flushed in its own cycle produces no response.
   always_comb begin
      owner_nxt = OWN_NONE;
      if (dbg_win)
         owner_nxt = OWN_DBG;
      else if (cpu_win && !cpu_flush)
         owner_nxt = OWN_CPU;
   end

   // Starvation counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         starve_cnt <= 4'd0;
      else
         starve_cnt <= starve_cnt_nxt;
   end

   // ---- stage p1: registered response ----

   // Response owner and misalignment flag; reset drops any pending response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_p1   <= OWN_NONE;
         dbg_err_p1 <= 1'b0;
      end else begin
         owner_p1   <= owner_nxt;
         dbg_err_p1 <= dbg_win & (dbg_addr[1:0] != 2'b00);
      end
   end

   // Capture the ROM word for the winner; the other requester's data holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cpu_inst <= '0;
         dbg_inst <= '0;
      end else begin
         if (owner_nxt == OWN_CPU)
            cpu_inst <= rom_inst;
         if (owner_nxt == OWN_DBG)
            dbg_inst <= rom_inst;
      end
   end

   // A flush in the response cycle kills the CPU response that is in flight.
   assign cpu_valid = (owner_p1 == OWN_CPU) & ~cpu_flush;
   assign dbg_valid = (owner_p1 == OWN_DBG);
   assign dbg_err   = dbg_err_p1;

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Testbench for inst_rom_arbiter: directed scenarios followed by random
// traffic, all checked against a behavioural model of the arbitration rules.
module tb_inst_rom_arbiter;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int STARVE_MAX = 4;

   logic              clk;
   logic              rst;
   logic              cpu_req;
   logic [ADDR_W-1:0] cpu_addr;
   logic              cpu_flush;
   logic              cpu_stall;
   logic              cpu_valid;
   logic [DATA_W-1:0] cpu_inst;
   logic              dbg_req;
   logic [ADDR_W-1:0] dbg_addr;
   logic              dbg_gnt;
   logic              dbg_valid;
   logic [DATA_W-1:0] dbg_inst;
   logic              dbg_err;
   logic              rom_ce;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_inst;

   logic [31:0] rom_mem [0:255];

   int errors = 0;
   int checks = 0;

   // model state
   int          m_wait;
   logic        m_cpu_pend;
   logic [31:0] m_cpu_word;
   logic        m_dbg_pend;
   logic [31:0] m_dbg_word;
   logic        m_dbg_err;
   logic        g_cpu;
   logic        g_dbg;

   inst_rom_arbiter #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cpu_req(cpu_req),
      .cpu_addr(cpu_addr),
      .cpu_flush(cpu_flush),
      .cpu_stall(cpu_stall),
      .cpu_valid(cpu_valid),
      .cpu_inst(cpu_inst),
      .dbg_req(dbg_req),
      .dbg_addr(dbg_addr),
      .dbg_gnt(dbg_gnt),
      .dbg_valid(dbg_valid),
      .dbg_inst(dbg_inst),
      .dbg_err(dbg_err),
      .rom_ce(rom_ce),
      .rom_addr(rom_addr),
      .rom_inst(rom_inst)
   );

   // combinational ROM, word addressed by byte address bits [9:2]
   assign rom_inst = rom_mem[rom_addr[9:2]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return rom_mem[a[9:2]];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_wait     = 0;
      m_cpu_pend = 1'b0;
      m_cpu_word = 32'h0;
      m_dbg_pend = 1'b0;
      m_dbg_word = 32'h0;
      m_dbg_err  = 1'b0;
   endtask

   // One clock cycle: drive inputs, check outputs against the model, advance the model.
   task automatic cycle(input logic cr, input logic [31:0] ca, input logic cf,
                        input logic dr, input logic [31:0] da);
      logic dwin;
      logic cwin;
      @(negedge clk);
      cpu_req   = cr;
      cpu_addr  = ca;
      cpu_flush = cf;
      dbg_req   = dr;
      dbg_addr  = da;
      #1;
      dwin = dr && (!cr || m_wait == STARVE_MAX);
      cwin = cr && !dwin;
      chk("dbg_gnt", {31'b0, dbg_gnt}, {31'b0, dwin});
      chk("cpu_stall", {31'b0, cpu_stall}, {31'b0, cr && !cwin});
      chk("rom_ce", {31'b0, rom_ce}, {31'b0, cwin || dwin});
      chk("rom_addr", rom_addr, dwin ? da : (cwin ? ca : 32'h0));
      chk("cpu_valid", {31'b0, cpu_valid}, {31'b0, m_cpu_pend && !cf});
      if (m_cpu_pend && !cf)
         chk("cpu_inst", cpu_inst, m_cpu_word);
      chk("dbg_valid", {31'b0, dbg_valid}, {31'b0, m_dbg_pend});
      chk("dbg_err", {31'b0, dbg_err}, {31'b0, m_dbg_pend && m_dbg_err});
      chk("dbg_inst", dbg_inst, m_dbg_word);
      g_cpu = cwin;
      g_dbg = dwin;
      m_cpu_pend = cwin && !cf;
      if (m_cpu_pend)
         m_cpu_word = word_at(ca);
      m_dbg_pend = dwin;
      if (dwin) begin
         m_dbg_word = word_at(da);
         m_dbg_err  = (da[1:0] != 2'b00);
      end
      if (cwin && dr) begin
         if (m_wait < STARVE_MAX)
            m_wait++;
      end else begin
         m_wait = 0;
      end
   endtask

   initial begin
      logic        dpend;
      logic        cr;
      logic        cf;
      logic        dr;
      logic [31:0] ca;
      logic [31:0] da;

      for (int i = 0; i < 256; i++)
         rom_mem[i] = $urandom;
      rom_mem[0] = 32'h34011100;
      rom_mem[1] = 32'h34020020;
      rom_mem[2] = 32'h3403ff00;
      rom_mem[4] = 32'hA5A50004;

      model_reset();
      rst       = 1'b1;
      cpu_req   = 1'b1;
      cpu_addr  = 32'h40;
      cpu_flush = 1'b0;
      dbg_req   = 1'b1;
      dbg_addr  = 32'h44;

      // reset state, with requests present to confirm outputs are forced quiet
      #12;
      chk("rst_rom_ce", {31'b0, rom_ce}, 32'h0);
      chk("rst_rom_addr", rom_addr, 32'h0);
      chk("rst_dbg_gnt", {31'b0, dbg_gnt}, 32'h0);
      chk("rst_cpu_stall", {31'b0, cpu_stall}, 32'h0);
      chk("rst_cpu_valid", {31'b0, cpu_valid}, 32'h0);
      chk("rst_dbg_valid", {31'b0, dbg_valid}, 32'h0);
      chk("rst_dbg_err", {31'b0, dbg_err}, 32'h0);
      chk("rst_cpu_inst", cpu_inst, 32'h0);
      chk("rst_dbg_inst", dbg_inst, 32'h0);
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // CPU only, back-to-back
      cycle(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
      cycle(1'b1, 32'h4, 1'b0, 1'b0, 32'h0);
      chk("cpu_word0", cpu_inst, 32'h34011100);
      cycle(1'b1, 32'h8, 1'b0, 1'b0, 32'h0);
      chk("cpu_word1", cpu_inst, 32'h34020020);
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("cpu_word2", cpu_inst, 32'h3403ff00);

      // debug only
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h10);
      chk("dbg_only_gnt", {31'b0, dbg_gnt}, 32'h1);
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("dbg_only_valid", {31'b0, dbg_valid}, 32'h1);
      chk("dbg_only_word", dbg_inst, 32'hA5A50004);
      chk("dbg_only_ce_off", {31'b0, rom_ce}, 32'h0);

      // starvation: CPU wins four times, then debug takes a slot
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 32'h40 + 32'(4 * i), 1'b0, 1'b1, 32'h30);
         chk("starve_gnt", {31'b0, dbg_gnt}, (i == 4) ? 32'h1 : 32'h0);
         chk("starve_stall", {31'b0, cpu_stall}, (i == 4) ? 32'h1 : 32'h0);
      end
      cycle(1'b1, 32'h54, 1'b0, 1'b0, 32'h0);
      chk("starve_cpu_again", {31'b0, cpu_stall}, 32'h0);
      cycle(1'b1, 32'h58, 1'b0, 1'b1, 32'h34);
      chk("starve_cleared", {31'b0, dbg_gnt}, 32'h0);
      for (int i = 0; i < 4; i++)
         cycle(1'b1, 32'h5c + 32'(4 * i), 1'b0, 1'b1, 32'h34);
      chk("starve_second_gnt", {31'b0, dbg_gnt}, 32'h1);

      // flush in the response cycle
      cycle(1'b1, 32'h20, 1'b0, 1'b0, 32'h0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      chk("flush_kill", {31'b0, cpu_valid}, 32'h0);
      cycle(1'b1, 32'h24, 1'b0, 1'b0, 32'h0);
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("flush_next_valid", {31'b0, cpu_valid}, 32'h1);
      chk("flush_next_word", cpu_inst, rom_mem[9]);

      // flush in the grant cycle
      cycle(1'b1, 32'h28, 1'b1, 1'b0, 32'h0);
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("flush_at_grant", {31'b0, cpu_valid}, 32'h0);

      // misaligned debug address
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h13);
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("misalign_valid", {31'b0, dbg_valid}, 32'h1);
      chk("misalign_err", {31'b0, dbg_err}, 32'h1);
      chk("misalign_word", dbg_inst, 32'hA5A50004);

      // asynchronous reset right after a CPU grant
      cycle(1'b1, 32'h30, 1'b0, 1'b0, 32'h0);
      @(posedge clk);
      #2;
      rst     = 1'b1;
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      #1;
      chk("arst_cpu_valid", {31'b0, cpu_valid}, 32'h0);
      chk("arst_rom_ce", {31'b0, rom_ce}, 32'h0);
      chk("arst_cpu_inst", cpu_inst, 32'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++)
         cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

      // random traffic; debug request held with stable address until granted
      dpend = 1'b0;
      da    = 32'h0;
      for (int n = 0; n < 500; n++) begin
         cr = ($urandom_range(0, 9) < 7);
         cf = ($urandom_range(0, 9) == 0);
         ca = 32'($urandom_range(0, 1023)) & 32'hFFFF_FFFC;
         if (dpend) begin
            dr = 1'b1;
         end else begin
            dr = ($urandom_range(0, 2) == 0);
            da = 32'($urandom_range(0, 1023));
         end
         cycle(cr, ca, cf, dr, dr ? da : 32'h0);
         dpend = dr && !g_dbg;
      end
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
